// File: rtl/stopwatch_bcd.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : stopwatch_bcd                                           |
// | Purpose  : Counts syscnt enable pulses into a BCD mm:ss display,   |
// |            00:00..59:59, under start/stop/clear control.           |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module stopwatch_bcd #(
  parameter int TICKS_PER_SEC = 1,
  parameter int PRESC_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       syscnt,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       wrap
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic               sec_due;

  // Counting is qualified by the state held before the edge, so a
  // start_stop arriving with syscnt in RUN still gets that pulse counted.
  assign tick    = (state == RUN) && syscnt;
  assign sec_due = (presc == PRESC_MAX);

  // Next-state decode: clear dominates, then start_stop toggles run/pause.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else if (start_stop) begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register; running is registered from the next state so it lines
  // up with the state itself and has no path from inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
    end
  end

  // Prescaler and BCD carry chain; wrap marks the 59:59 -> 00:00 rollover.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc    <= '0;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
      wrap     <= 1'b0;
    end else if (clear) begin
      presc    <= '0;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (tick) begin
        if (sec_due) begin
          presc <= '0;
          if (sec_ones == 4'd9) begin
            sec_ones <= 4'd0;
            if (sec_tens == 4'd5) begin
              sec_tens <= 4'd0;
              if (min_ones == 4'd9) begin
                min_ones <= 4'd0;
                if (min_tens == 4'd5) begin
                  min_tens <= 4'd0;
                  wrap     <= 1'b1;
                end else begin
                  min_tens <= min_tens + 4'd1;
                end
              end else begin
                min_ones <= min_ones + 4'd1;
              end
            end else begin
              sec_tens <= sec_tens + 4'd1;
            end
          end else begin
            sec_ones <= sec_ones + 4'd1;
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_bcd.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_stopwatch_bcd                                        |
// | Purpose  : Scoreboard bench for stopwatch_bcd, one instance with   |
// |            TICKS_PER_SEC=1 and one with TICKS_PER_SEC=4.           |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_stopwatch_bcd;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic syscnt = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;

  logic [3:0] so1, st1, mo1, mt1, so4, st4, mo4, mt4;
  logic       run1, wrap1, run4, wrap4;

  int checks = 0;
  int errors = 0;
  string phase = "init";

  typedef struct {
    int st;     // 0 idle, 1 run, 2 pause
    int secs;   // 0..3599
    int presc;
    bit wrap;
  } model_t;

  typedef struct packed {
    logic [17:0] e1;
    logic [17:0] e4;
  } exp_t;

  model_t m1, m4;
  exp_t   sb_q[$];

  stopwatch_bcd #(.TICKS_PER_SEC(1), .PRESC_W(16)) dut1 (
    .clk(clk), .rst(rst), .syscnt(syscnt), .start_stop(start_stop),
    .clear(clear), .sec_ones(so1), .sec_tens(st1), .min_ones(mo1),
    .min_tens(mt1), .running(run1), .wrap(wrap1)
  );

  stopwatch_bcd #(.TICKS_PER_SEC(4), .PRESC_W(3)) dut4 (
    .clk(clk), .rst(rst), .syscnt(syscnt), .start_stop(start_stop),
    .clear(clear), .sec_ones(so4), .sec_tens(st4), .min_ones(mo4),
    .min_tens(mt4), .running(run4), .wrap(wrap4)
  );

  always #5 clk = ~clk;

  wire [17:0] obs1 = {mt1, mo1, st1, so1, run1, wrap1};
  wire [17:0] obs4 = {mt4, mo4, st4, so4, run4, wrap4};

  // Compare one observed value against the expected one and count it.
  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour: time held as plain seconds, display derived by div/mod.
  function automatic model_t advance(input model_t m, input int t, input bit rn,
                                     input bit c, input bit ss, input bit sc);
    model_t n = m;
    if (!rn) begin
      n.st = 0; n.secs = 0; n.presc = 0; n.wrap = 0;
    end else if (c) begin
      n.st = 0; n.secs = 0; n.presc = 0; n.wrap = 0;
    end else begin
      n.wrap = 0;
      if (m.st == 1 && sc) begin
        if (m.presc == t - 1) begin
          n.presc = 0;
          if (m.secs == 3599) begin
            n.secs = 0;
            n.wrap = 1;
          end else begin
            n.secs = m.secs + 1;
          end
        end else begin
          n.presc = m.presc + 1;
        end
      end
      if (ss) n.st = (m.st == 1) ? 2 : 1;
    end
    return n;
  endfunction

  function automatic logic [17:0] pack_exp(input model_t m);
    int mins = m.secs / 60;
    int s    = m.secs % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10),
            (m.st == 1), m.wrap};
  endfunction

  // One clock of stimulus: push the model prediction, then pop and compare.
  task automatic step(input bit rn, input bit c, input bit ss, input bit sc);
    exp_t e;
    @(negedge clk);
    rst = rn; clear = c; start_stop = ss; syscnt = sc;
    m1 = advance(m1, 1, rn, c, ss, sc);
    m4 = advance(m4, 4, rn, c, ss, sc);
    sb_q.push_back('{pack_exp(m1), pack_exp(m4)});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({phase, "_t1"}, obs1, e.e1);
    check({phase, "_t4"}, obs4, e.e4);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 1);
      step(1, 0, 0, 0);
    end
  endtask

  task automatic restart();
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
  endtask

  initial begin
    m1 = '{0, 0, 0, 0};
    m4 = '{0, 0, 0, 0};

    phase = "reset";
    repeat (10) step(0, 0, 0, 0);
    check("reset_zero", obs1, 18'h0);

    phase = "start";
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    check("start_running", obs1, {16'h0000, 1'b1, 1'b0});
    pulses(75);
    check("count_01_15", obs1, {16'h0115, 1'b1, 1'b0});
    check("t4_00_18", obs4, {16'h0018, 1'b1, 1'b0});

    phase = "presc";
    restart();
    pulses(7);
    check("presc_7", obs4, {16'h0001, 1'b1, 1'b0});
    pulses(1);
    check("presc_8", obs4, {16'h0002, 1'b1, 1'b0});

    phase = "pause";
    restart();
    pulses(5);
    check("at_00_05", obs1, {16'h0005, 1'b1, 1'b0});
    step(1, 0, 1, 1);
    check("pause_counted", obs1, {16'h0006, 1'b0, 1'b0});
    step(1, 0, 0, 0);
    pulses(10);
    check("pause_hold", obs1, {16'h0006, 1'b0, 1'b0});
    step(1, 0, 1, 0);
    pulses(1);
    check("resume", obs1, {16'h0007, 1'b1, 1'b0});

    phase = "rollover";
    restart();
    pulses(3599);
    check("at_59_59", obs1, {16'h5959, 1'b1, 1'b0});
    step(1, 0, 0, 1);
    check("wrap_pulse", obs1, {16'h0000, 1'b1, 1'b1});
    step(1, 0, 0, 0);
    check("wrap_drop", obs1, {16'h0000, 1'b1, 1'b0});
    pulses(1);
    check("after_wrap", obs1, {16'h0001, 1'b1, 1'b0});

    phase = "clear";
    restart();
    pulses(754);
    check("at_12_34", obs1, {16'h1234, 1'b1, 1'b0});
    step(1, 1, 1, 1);
    check("clear_prio", obs1, 18'h0);
    step(1, 0, 0, 0);
    pulses(2);
    check("idle_nocount", obs1, 18'h0);

    phase = "midreset";
    restart();
    pulses(201);
    step(1, 0, 1, 0);
    check("paused_03_21", obs1, {16'h0321, 1'b0, 1'b0});
    step(0, 0, 0, 0);
    check("midreset_zero", obs1, 18'h0);
    check("midreset_zero4", obs4, 18'h0);
    step(1, 0, 0, 0);
    pulses(3);
    check("reset_nocount", obs1, 18'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
